spi_resp: RTL and testbench
===========================

Name: spi_resp

Overview:
- SPI responder (slave) for the 16-bit SPI master used in the design.
- Bus is mode 3: SCLK idles high, SS_n active low, MSB first. The master changes MOSI on SCLK fall and samples MISO just before SCLK rises.
- Receives one WIDTH-bit word per SS_n-low frame and returns tx_data on MISO. Gives sensor/peripheral models and on-chip register banks a clk-domain rx_data/rdy handshake.

Parameters:
WIDTH, 16, frame length in bits; also the width of tx_data and rx_data.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active low
SS_n  input  1  slave select from master, asynchronous to clk
SCLK  input  1  serial clock from master, asynchronous to clk
MOSI  input  1  serial data from master, asynchronous to clk
MISO  output  1  serial data to master; always driven, equals shft_reg[WIDTH-1]
tx_data  input  WIDTH  response word, captured at frame start
rx_data  output  WIDTH  last complete word received
rdy  output  1  rx_data valid; held high until clr_rdy or the next frame start
clr_rdy  input  1  clears rdy
err  output  1  one-cycle pulse on a frame that ends with a bit count other than WIDTH

Behaviour:
- Reset (rst_n low at a clk rising edge), applied regardless of state or mid-frame:
  - state=IDLE, shft_reg=0, so MISO=0.
  - rx_data=0, rdy=0, err=0, bit_cnt=0.
  - Synchronizer flops preset to 1 for SS_n and SCLK, and 0 for MOSI.
- Synchronization:
  - SS_n, SCLK and MOSI each pass through a 2-flop synchronizer, plus a third flop for edge detection.
  - All three signals use identical depth, so MOSI stays aligned with SCLK.
  - sclk_rise = stage2 & ~stage3. ss_fall = ~stage2 & stage3. ss_rise = stage2 & ~stage3.
  - Edge-to-action latency is 3 clk cycles. Requirement: SCLK high and low times, and MOSI setup to SCLK rise, are each at least 4 clk periods. The master provides 16/32.
- States:
  - IDLE -> ACTIVE on ss_fall: shft_reg<=tx_data, bit_cnt<=0, rdy<=0. MISO shows tx_data[WIDTH-1] within 1 cycle after detection.
  - ACTIVE, on each sclk_rise: shft_reg<={shft_reg[WIDTH-2:0], MOSI_sync}, bit_cnt<=bit_cnt+1. MISO changes right after the rise; the master samples a full half-period later.
  - ACTIVE, SCLK falls: ignored. The master's first fall precedes any rise, and its final bit has no trailing fall.
  - ACTIVE -> IDLE on ss_rise:
    - If bit_cnt==WIDTH: rx_data<=shft_reg, rdy<=1.
    - Otherwise: err pulses 1 cycle; rx_data and rdy are unchanged.
- bit_cnt:
  - Width is clog2(WIDTH)+1 bits.
  - Saturates at WIDTH+1, so an overlong frame reports err.
  - sclk_rise in IDLE is ignored; bit_cnt does not change.
- ss_fall while in ACTIVE cannot occur (SS_n must rise first). An ss_rise in IDLE is ignored.
- clr_rdy forces rdy<=0.
  - clr_rdy in the same cycle as a completing ss_rise: set wins, rdy=1.
  - ss_fall always clears rdy; a new frame invalidates the old handshake, but rx_data holds its value.
- tx_data is sampled only at ss_fall. Changes during a frame do not affect MISO.
- Back-to-back frames with SS_n high for at least 4 clk periods are each captured independently.

Test Plan:
- Reset then idle: rst_n low 2 cycles with SS_n=1 and SCLK=1 -> MISO=0, rx_data=0x0000, rdy=0, err=0.
- Loopback with the team SPI master:
  - Setup: master cmd=0xA5C3, tx_data=0x3C5A, wrt pulsed.
  - Responder: rdy=1, rx_data=0xA5C3 within 4 cycles of SS_n rising.
  - Master: done=1 with rd_data=0x3C5A.
- Back-to-back frames: frame 0x0001 then 0xFFFE, rdy cleared by clr_rdy between them -> rx_data=0x0001 then 0xFFFE. rdy drops at the second SS_n fall even if clr_rdy is withheld.
- Short frame: bit-banged SS_n low with 8 SCLK rises (MOSI=1), then SS_n high -> err pulses exactly 1 cycle, rdy=0, rx_data holds its previous value.
- Overlong frame: 17 rises -> err=1 pulse, no rdy.
- Reset mid-frame: rst_n low after 5 of 16 rises, released, then a full frame 0x1234 -> rx_data=0x1234, rdy=1, no err.
- clr_rdy collision: clr_rdy asserted in the exact cycle rdy would set -> rdy=1. clr_rdy one cycle later -> rdy=0.

Source files
------------

// File: rtl/spi_resp_if.sv
// SPI mode-3 bus plus the clk-domain receive handshake of the SPI responder.
// The slave modport is the responder's view; the master modport is the view
// of whatever drives the bus (SPI master, bus-functional model).
interface spi_resp_if #(
   parameter int WIDTH = 16
);
   logic             SS_n;
   logic             SCLK;
   logic             MOSI;
   logic             MISO;
   logic [WIDTH-1:0] tx_data;
   logic [WIDTH-1:0] rx_data;
   logic             rdy;
   logic             clr_rdy;
   logic             err;

   modport slave (
      input  SS_n, SCLK, MOSI, tx_data, clr_rdy,
      output MISO, rx_data, rdy, err
   );

   modport master (
      output SS_n, SCLK, MOSI, tx_data, clr_rdy,
      input  MISO, rx_data, rdy, err
   );
endinterface

// File: rtl/spi_resp.sv
// SPI responder (mode 3, MSB first). Receives one WIDTH-bit word per SS_n-low
// frame while returning the word captured from tx_data at frame start.
// SS_n/SCLK/MOSI are asynchronous and are synchronized into clk before use.
module spi_resp #(
   parameter int WIDTH = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   spi_resp_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       ss_q, ss_d;
   logic [2:0]       sclk_q, sclk_d;
   // MOSI is consumed at stage 2, the same depth as the SCLK stage that
   // produces sclk_rise, so it needs no third (edge-detect) flop.
   logic [1:0]       mosi_q, mosi_d;
   logic [WIDTH-1:0] shft_q, shft_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic             rdy_q, rdy_d;
   logic             err_q, err_d;

   logic             sclk_rise, ss_fall, ss_rise, mosi_sync;

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign ss_fall   = ~ss_q[1] & ss_q[2];
   assign ss_rise   = ss_q[1] & ~ss_q[2];
   assign mosi_sync = mosi_q[1];

   assign bus.MISO    = shft_q[WIDTH-1];
   assign bus.rx_data = rx_q;
   assign bus.rdy     = rdy_q;
   assign bus.err     = err_q;

   // State and datapath registers; synchronizers preset to the bus idle level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ss_q      <= 3'b111;
         sclk_q    <= 3'b111;
         mosi_q    <= 2'b00;
         shft_q    <= '0;
         bit_cnt_q <= '0;
         rx_q      <= '0;
         rdy_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ss_q      <= ss_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         shft_q    <= shft_d;
         bit_cnt_q <= bit_cnt_d;
         rx_q      <= rx_d;
         rdy_q     <= rdy_d;
         err_q     <= err_d;
      end
   end

   // Synchronizer shift chains: bit 0 is the first stage.
   always_comb begin
      ss_d   = {ss_q[1:0], bus.SS_n};
      sclk_d = {sclk_q[1:0], bus.SCLK};
      mosi_d = {mosi_q[0], bus.MOSI};
   end

   // Next state: a frame spans synchronized SS_n fall to SS_n rise.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ss_fall) state_d = ACTIVE;
         ACTIVE:  if (ss_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: load at frame start, shift on SCLK rise, judge bit count at end.
   always_comb begin
      shft_d    = shft_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      rdy_d     = rdy_q;
      err_d     = 1'b0;
      if (bus.clr_rdy) rdy_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               shft_d    = bus.tx_data;
               bit_cnt_d = '0;
               rdy_d     = 1'b0;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               // Completion is evaluated last so it overrides a same-cycle clr_rdy.
               if (bit_cnt_q == CNT_FULL) begin
                  rx_d  = shft_q;
                  rdy_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (sclk_rise) begin
               shft_d = {shft_q[WIDTH-2:0], mosi_sync};
               // Saturate one past WIDTH so an overlong frame still reports err.
               if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spi_resp.sv
// Bench for spi_resp: a bit-banged mode-3 master drives frames with 16-clk
// half periods; expected receive and read-back words go through scoreboards.
module tb_spi_resp;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] miso_q[$];

   always #5 clk = ~clk;

   spi_resp_if #(.WIDTH(W)) bus ();

   spi_resp #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Lower SS_n and clock nbits bits; SS_n is left low at the end.
   task automatic drive_bits(input logic [W-1:0] word, input int nbits,
                             input bit change_tx, input logic [W-1:0] tx_mid,
                             output logic [W-1:0] rd);
      rd = '0;
      bus.SS_n = 1'b0;
      wait_clks(16);
      for (int i = 0; i < nbits; i++) begin
         bus.SCLK = 1'b0;
         bus.MOSI = (i < W) ? word[W-1-i] : 1'b0;
         if (i == 0 && change_tx) bus.tx_data = tx_mid;
         wait_clks(16);
         if (i < W) rd[W-1-i] = bus.MISO;
         bus.SCLK = 1'b1;
         wait_clks(16);
      end
   endtask

   // Raise SS_n and watch 8 cycles for err pulses and the first rdy cycle.
   task automatic end_frame(output int err_cnt, output int rdy_at);
      bus.SS_n = 1'b1;
      err_cnt = 0;
      rdy_at = -1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (bus.err === 1'b1) err_cnt++;
         if (rdy_at < 0 && bus.rdy === 1'b1) rdy_at = c;
      end
   endtask

   task automatic pulse_clr();
      bus.clr_rdy = 1'b1;
      @(negedge clk);
      bus.clr_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.SS_n = 1'b1;
      bus.SCLK = 1'b1;
      bus.MOSI = 1'b0;
      bus.tx_data = '0;
      bus.clr_rdy = 1'b0;
      wait_clks(2);
      rst_n = 1'b1;
      wait_clks(2);
      total++; if (bus.MISO !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", bus.MISO); end
      total++; if (bus.rx_data !== 16'h0000) begin bad++; $display("FAIL reset_rx got=%h want=0000", bus.rx_data); end
      total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", bus.rdy); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
   endtask

   task automatic test_loopback();
      logic [W-1:0] rd, e;
      int ec, ra;
      bus.tx_data = 16'h3C5A;
      exp_q.push_back(16'hA5C3);
      miso_q.push_back(16'h3C5A);
      // tx_data changes after frame start must not reach MISO.
      drive_bits(16'hA5C3, 16, 1'b1, 16'hFFFF, rd);
      end_frame(ec, ra);
      total++; if (ra < 1 || ra > 4) begin bad++; $display("FAIL loop_rdy_latency got=%0d want=1..4", ra); end
      e = exp_q.pop_front();
      total++; if (bus.rx_data !== e) begin bad++; $display("FAIL loop_rx got=%h want=%h", bus.rx_data, e); end
      e = miso_q.pop_front();
      total++; if (rd !== e) begin bad++; $display("FAIL loop_miso got=%h want=%h", rd, e); end
      total++; if (ec != 0) begin bad++; $display("FAIL loop_err got=%0d want=0", ec); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] rd, e;
      int ec, ra;
      wait_clks(8);
      bus.tx_data = 16'h1111;
      exp_q.push_back(16'h0001);
      miso_q.push_back(16'h1111);
      drive_bits(16'h0001, 16, 1'b0, '0, rd);
      end_frame(ec, ra);
      e = exp_q.pop_front();
      total++; if (ra < 1 || bus.rx_data !== e) begin bad++; $display("FAIL b2b_rx0 got=%h rdy_at=%0d want=%h", bus.rx_data, ra, e); end
      e = miso_q.pop_front();
      total++; if (rd !== e) begin bad++; $display("FAIL b2b_miso0 got=%h want=%h", rd, e); end
      pulse_clr();
      total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL b2b_clr got=%b want=0", bus.rdy); end
      wait_clks(8);
      bus.tx_data = 16'h8001;
      exp_q.push_back(16'hFFFE);
      miso_q.push_back(16'h8001);
      drive_bits(16'hFFFE, 16, 1'b0, '0, rd);
      end_frame(ec, ra);
      e = exp_q.pop_front();
      total++; if (ra < 1 || bus.rx_data !== e) begin bad++; $display("FAIL b2b_rx1 got=%h rdy_at=%0d want=%h", bus.rx_data, ra, e); end
      e = miso_q.pop_front();
      total++; if (rd !== e) begin bad++; $display("FAIL b2b_miso1 got=%h want=%h", rd, e); end
      // Next frame start with rdy still set and no clr_rdy.
      wait_clks(8);
      bus.tx_data = 16'hAAAA;
      bus.SS_n = 1'b0;
      wait_clks(5);
      total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL b2b_ssfall_rdy got=%b want=0", bus.rdy); end
      total++; if (bus.rx_data !== 16'hFFFE) begin bad++; $display("FAIL b2b_ssfall_rx got=%h want=fffe", bus.rx_data); end
      exp_q.push_back(16'h5555);
      miso_q.push_back(16'hAAAA);
      drive_bits(16'h5555, 16, 1'b0, '0, rd);
      end_frame(ec, ra);
      e = exp_q.pop_front();
      total++; if (ra < 1 || bus.rx_data !== e) begin bad++; $display("FAIL b2b_rx2 got=%h rdy_at=%0d want=%h", bus.rx_data, ra, e); end
      e = miso_q.pop_front();
      total++; if (rd !== e) begin bad++; $display("FAIL b2b_miso2 got=%h want=%h", rd, e); end
   endtask

   task automatic test_short_frame();
      logic [W-1:0] rd;
      int ec, ra;
      pulse_clr();
      wait_clks(8);
      drive_bits(16'hFFFF, 8, 1'b0, '0, rd);
      end_frame(ec, ra);
      total++; if (ec != 1) begin bad++; $display("FAIL short_err got=%0d want=1", ec); end
      total++; if (ra != -1) begin bad++; $display("FAIL short_rdy got=%0d want=-1", ra); end
      total++; if (bus.rx_data !== 16'h5555) begin bad++; $display("FAIL short_rx got=%h want=5555", bus.rx_data); end
   endtask

   task automatic test_overlong_frame();
      logic [W-1:0] rd;
      int ec, ra;
      wait_clks(8);
      drive_bits(16'h0F0F, 17, 1'b0, '0, rd);
      end_frame(ec, ra);
      total++; if (ec != 1) begin bad++; $display("FAIL long_err got=%0d want=1", ec); end
      total++; if (ra != -1) begin bad++; $display("FAIL long_rdy got=%0d want=-1", ra); end
      total++; if (bus.rx_data !== 16'h5555) begin bad++; $display("FAIL long_rx got=%h want=5555", bus.rx_data); end
   endtask

   task automatic test_reset_mid_frame();
      logic [W-1:0] rd, e;
      int ec, ra;
      wait_clks(8);
      bus.tx_data = 16'hFFFF;
      drive_bits(16'h9999, 5, 1'b0, '0, rd);
      rst_n = 1'b0;
      bus.SS_n = 1'b1;
      bus.SCLK = 1'b1;
      bus.MOSI = 1'b0;
      wait_clks(2);
      total++; if (bus.MISO !== 1'b0) begin bad++; $display("FAIL rstmid_miso got=%b want=0", bus.MISO); end
      total++; if (bus.rx_data !== 16'h0000) begin bad++; $display("FAIL rstmid_rx got=%h want=0000", bus.rx_data); end
      rst_n = 1'b1;
      wait_clks(8);
      bus.tx_data = 16'h4321;
      exp_q.push_back(16'h1234);
      miso_q.push_back(16'h4321);
      drive_bits(16'h1234, 16, 1'b0, '0, rd);
      end_frame(ec, ra);
      e = exp_q.pop_front();
      total++; if (ra < 1 || bus.rx_data !== e) begin bad++; $display("FAIL rstmid_frame_rx got=%h rdy_at=%0d want=%h", bus.rx_data, ra, e); end
      total++; if (ec != 0) begin bad++; $display("FAIL rstmid_frame_err got=%0d want=0", ec); end
      e = miso_q.pop_front();
      total++; if (rd !== e) begin bad++; $display("FAIL rstmid_frame_miso got=%h want=%h", rd, e); end
   endtask

   task automatic test_clr_collision();
      logic [W-1:0] rd, e;
      wait_clks(8);
      bus.tx_data = 16'h0F0F;
      exp_q.push_back(16'hBEEF);
      drive_bits(16'hBEEF, 16, 1'b0, '0, rd);
      bus.SS_n = 1'b1;
      wait_clks(2);
      total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL coll_pre_rdy got=%b want=0", bus.rdy); end
      bus.clr_rdy = 1'b1;
      @(negedge clk);
      bus.clr_rdy = 1'b0;
      total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL coll_same_cycle_rdy got=%b want=1", bus.rdy); end
      e = exp_q.pop_front();
      total++; if (bus.rx_data !== e) begin bad++; $display("FAIL coll_rx got=%h want=%h", bus.rx_data, e); end
      wait_clks(8);
      exp_q.push_back(16'h7E57);
      drive_bits(16'h7E57, 16, 1'b0, '0, rd);
      bus.SS_n = 1'b1;
      wait_clks(3);
      total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL coll_late_set got=%b want=1", bus.rdy); end
      bus.clr_rdy = 1'b1;
      @(negedge clk);
      bus.clr_rdy = 1'b0;
      total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL coll_late_clr got=%b want=0", bus.rdy); end
      e = exp_q.pop_front();
      total++; if (bus.rx_data !== e) begin bad++; $display("FAIL coll_late_rx got=%h want=%h", bus.rx_data, e); end
   endtask

   initial begin
      bus.SS_n = 1'b1;
      bus.SCLK = 1'b1;
      bus.MOSI = 1'b0;
      bus.tx_data = '0;
      bus.clr_rdy = 1'b0;
      test_reset();
      test_loopback();
      test_back_to_back();
      test_short_frame();
      test_overlong_frame();
      test_reset_mid_frame();
      test_clr_collision();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
